// File: rtl/cache_mem_pkg.sv
// +--------------------------------------------------------------------+
// | cache_mem_pkg : shared types and constants for cache_mem_ctrl      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cache_mem_pkg;

  localparam int LINE_ADDR_W     = 28;
  localparam int LINE_W          = 128;
  localparam int DEFAULT_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB   = 3'd1,
    ST_GAP  = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_req_timer.sv
// +--------------------------------------------------------------------+
// | mem_req_timer : clearable counter that saturates at LIMIT (o_tc)   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_req_timer #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LIMIT);

endmodule

`default_nettype wire

// File: rtl/cache_mem_ctrl.sv
// +--------------------------------------------------------------------+
// | cache_mem_ctrl : miss handler, optional writeback then line refill |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module cache_mem_ctrl #(
  parameter int ADDR_W  = cache_mem_pkg::LINE_ADDR_W,
  parameter int LINE_W  = cache_mem_pkg::LINE_W,
  parameter int TIMEOUT = cache_mem_pkg::DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_dirty,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [LINE_W-1:0] req_wb_data,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              req_ready,
  output logic [LINE_W-1:0] fill_data,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  busy_cycles,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  import cache_mem_pkg::*;

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_fill_addr;

  logic              w_in_req;
  logic              w_tmr_clr;
  logic              w_tmr_inc;
  logic              w_tmr_tc;
  logic [TMR_W-1:0]  w_tmr_cnt_unused;
  logic              w_busy_sat_unused;

  assign w_in_req  = (r_state == ST_WB) || (r_state == ST_FILL);
  assign w_tmr_clr = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_GAP);
  assign w_tmr_inc = w_in_req && !mem_ready;

  // Terminal one short of TIMEOUT: the abort edge is the one that would make the count reach TIMEOUT.
  mem_req_timer #(
    .WIDTH (TMR_W),
    .LIMIT (TMR_W'(TIMEOUT - 1))
  ) u_hs_timer (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_tmr_clr),
    .i_inc (w_tmr_inc),
    .o_cnt (w_tmr_cnt_unused),
    .o_tc  (w_tmr_tc)
  );

  mem_req_timer #(
    .WIDTH (CNT_W)
  ) u_busy_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_inc (r_state != ST_IDLE),
    .o_cnt (busy_cycles),
    .o_tc  (w_busy_sat_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fill_addr <= '0;
      req_ready   <= 1'b1;
      fill_data   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready   <= 1'b0;
            r_fill_addr <= req_fill_addr;
            if (req_dirty) begin
              r_state   <= ST_WB;
              mem_write <= 1'b1;
              mem_addr  <= req_wb_addr;
              mem_wdata <= req_wb_data;
            end else begin
              r_state  <= ST_FILL;
              mem_read <= 1'b1;
              mem_addr <= req_fill_addr;
            end
          end
        end
        ST_WB: begin
          if (mem_ready) begin
            mem_write <= 1'b0;
            r_state   <= ST_GAP;
          end else if (w_tmr_tc) begin
            mem_write <= 1'b0;
            err       <= 1'b1;
            req_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_GAP: begin
          mem_read <= 1'b1;
          mem_addr <= r_fill_addr;
          r_state  <= ST_FILL;
        end
        ST_FILL: begin
          if (mem_ready) begin
            mem_read  <= 1'b0;
            fill_data <= mem_rdata;
            done      <= 1'b1;
            r_state   <= ST_DONE;
          end else if (w_tmr_tc) begin
            mem_read  <= 1'b0;
            err       <= 1'b1;
            req_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_DONE: begin
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          req_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_cache_mem_ctrl : randomized bench with cycle-phase reference    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cache_mem_ctrl;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam int TO = 15;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_dirty = 1'b0;
  logic [AW-1:0] req_wb_addr = '0;
  logic [LW-1:0] req_wb_data = '0;
  logic [AW-1:0] req_fill_addr = '0;
  logic          req_ready;
  logic [LW-1:0] fill_data;
  logic          done;
  logic          err;
  logic [CW-1:0] busy_cycles;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  cache_mem_ctrl #(
    .ADDR_W  (AW),
    .LINE_W  (LW),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dirty     (req_dirty),
    .req_wb_addr   (req_wb_addr),
    .req_wb_data   (req_wb_data),
    .req_fill_addr (req_fill_addr),
    .req_ready     (req_ready),
    .fill_data     (fill_data),
    .done          (done),
    .err           (err),
    .busy_cycles   (busy_cycles),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // mem is what the slow memory stores (written from DUT outputs); ref_mem is what the core intended.
  logic [127:0] mem     [logic [27:0]];
  logic [127:0] ref_mem [logic [27:0]];
  logic [127:0] exp_fill = '0;
  int           exp_busy = 0;

  function automatic logic [127:0] seed_line(input logic [27:0] a);
    return {4{a, 4'hA}};
  endfunction

  function automatic logic [127:0] mem_rd(input logic [27:0] a);
    return mem.exists(a) ? mem[a] : seed_line(a);
  endfunction

  function automatic logic [127:0] ref_rd(input logic [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_line(a);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // lat < 0 means memory never answers that phase.
  task automatic run_txn(input bit dirty, input logic [27:0] wba, input logic [127:0] wbd,
                         input logic [27:0] fa, input int wlat, input int rlat, input bit hold);
    byte ph[$];
    bit  abort = 0;
    bit  last;
    if (dirty) begin
      repeat ((wlat < 0) ? TO : wlat + 1) ph.push_back("W");
      if (wlat < 0) abort = 1;
      else ph.push_back("G");
    end
    if (!abort) begin
      repeat ((rlat < 0) ? TO : rlat + 1) ph.push_back("R");
      if (rlat < 0) abort = 1;
      else ph.push_back("D");
    end
    exp_busy += ph.size();
    ph.push_back(abort ? "E" : "I");

    req_valid     = 1'b1;
    req_dirty     = dirty;
    req_wb_addr   = wba;
    req_wb_data   = wbd;
    req_fill_addr = fa;
    mem_ready     = 1'($urandom_range(0, 1));
    mem_rdata     = rnd128();

    for (int k = 0; k < ph.size(); k++) begin
      @(negedge clk);
      check_val("mem_read",  128'(mem_read),  128'(ph[k] == "R"));
      check_val("mem_write", 128'(mem_write), 128'(ph[k] == "W"));
      check_val("done",      128'(done),      128'(ph[k] == "D"));
      check_val("err",       128'(err),       128'(ph[k] == "E"));
      check_val("req_ready", 128'(req_ready), 128'(ph[k] == "I" || ph[k] == "E"));
      check_val("fill_data", fill_data, exp_fill);
      if (ph[k] == "W") begin
        check_val("wb_addr",  128'(mem_addr), 128'(wba));
        check_val("wb_wdata", mem_wdata, wbd);
      end
      if (ph[k] == "R") check_val("fill_addr", 128'(mem_addr), 128'(fa));
      if (k == ph.size() - 1) check_val("busy_cycles", 128'(busy_cycles), 128'(exp_busy));

      last = (k + 1 < ph.size()) && (ph[k+1] != ph[k]) && (ph[k+1] != "E");
      if (ph[k] == "W" && last) begin
        mem[mem_addr] = mem_wdata;
        ref_mem[wba]  = wbd;
        mem_ready     = 1'b1;
        mem_rdata     = rnd128();
      end else if (ph[k] == "R" && last) begin
        mem_rdata = mem_rd(mem_addr);
        exp_fill  = ref_rd(fa);
        mem_ready = 1'b1;
      end else if (ph[k] == "W" || ph[k] == "R") begin
        mem_ready = 1'b0;
        mem_rdata = rnd128();
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = rnd128();
      end
      if (!hold && k < ph.size() - 1) begin
        req_valid     = 1'($urandom_range(0, 1));
        req_dirty     = 1'($urandom_range(0, 1));
        req_wb_addr   = 28'($urandom);
        req_wb_data   = rnd128();
        req_fill_addr = 28'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = rnd128();
      @(negedge clk);
      check_val("idle_rd",    128'(mem_read),    128'(0));
      check_val("idle_wr",    128'(mem_write),   128'(0));
      check_val("idle_ready", 128'(req_ready),   128'(1));
      check_val("idle_done",  128'(done | err),  128'(0));
      check_val("idle_busy",  128'(busy_cycles), 128'(exp_busy));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_rd"},    128'(mem_read),    128'(0));
    check_val({tag, "_wr"},    128'(mem_write),   128'(0));
    check_val({tag, "_ready"}, 128'(req_ready),   128'(1));
    check_val({tag, "_done"},  128'(done),        128'(0));
    check_val({tag, "_err"},   128'(err),         128'(0));
    check_val({tag, "_busy"},  128'(busy_cycles), 128'(0));
    check_val({tag, "_addr"},  128'(mem_addr),    128'(0));
    check_val({tag, "_wdata"}, mem_wdata,         128'(0));
    check_val({tag, "_fill"},  fill_data,         128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int lat_w, lat_r;
    #1 rst = 1'b1;
    #1 check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset_held");
    rst = 1'b0;
    idle(2);

    // Clean miss, ready in the fifth request cycle.
    run_txn(0, '0, '0, 28'h0000040, 0, 4, 1);
    idle(1);
    // Dirty miss, then read back the written-back line.
    run_txn(1, 28'h0000010, {4{32'h11111111}}, 28'h0000020, 2, 3, 1);
    idle(1);
    run_txn(0, '0, '0, 28'h0000010, 0, 1, 1);
    idle(1);
    // Zero-latency memory.
    run_txn(0, '0, '0, 28'h0000041, 0, 0, 1);
    run_txn(1, 28'h0000042, rnd128(), 28'h0000043, 0, 0, 1);
    idle(1);
    // Timeouts and the last-cycle boundary.
    run_txn(0, '0, '0, 28'h0000055, 0, -1, 1);
    run_txn(1, 28'h0000066, rnd128(), 28'h0000067, -1, 0, 1);
    run_txn(0, '0, '0, 28'h0000056, 0, TO - 1, 1);
    run_txn(1, 28'h0000068, rnd128(), 28'h0000069, TO - 1, TO - 1, 1);
    idle(1);
    // Back-to-back with req_valid held.
    for (int i = 0; i < 3; i++) run_txn(0, '0, '0, 28'(32'h100 + i), 0, i + 1, 1);
    idle(2);

    // Reset two cycles into a fill.
    req_valid = 1'b1; req_dirty = 1'b0; req_fill_addr = 28'h0000077;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    check_val("pre_rst_rd", 128'(mem_read), 128'(1));
    #2 rst = 1'b1;
    #1 check_reset_state("async_rst");
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    exp_busy = 0;
    exp_fill = '0;
    idle(1);
    run_txn(0, '0, '0, 28'h0000077, 0, 2, 1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      lat_w = ($urandom_range(0, 9) == 9) ? -1 : int'($urandom_range(0, 6));
      lat_r = ($urandom_range(0, 9) == 9) ? -1 : int'($urandom_range(0, 6));
      run_txn(1'($urandom_range(0, 1)), 28'($urandom_range(0, 15)), rnd128(),
              28'($urandom_range(0, 15)), lat_w, lat_r, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
